// File: rtl/regfile_access_ctrl.sv
// Register-file port sequencer with busy scoreboard; operands valid two cycles after issue, plus one per colliding writeback.
// Issue stalls on hazard, pending writeback or an unconsumed operand; writebacks take the port first and are never stalled.
module regfile_access_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_issue_valid,
    output logic        o_issue_ready,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [4:0]  i_rd,
    input  logic        i_rd_we,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_val,
    output logic        o_rf_en,
    output logic        o_op,
    output logic [4:0]  o_r_reg_num_1,
    output logic [4:0]  o_r_reg_num_2,
    input  logic [31:0] i_r_reg_1,
    input  logic [31:0] i_r_reg_2,
    output logic [4:0]  o_w_reg_num,
    output logic [31:0] o_w_val,
    output logic        o_opnd_valid,
    input  logic        i_opnd_ready,
    output logic [31:0] o_opnd_1,
    output logic [31:0] o_opnd_2,
    output logic [4:0]  o_opnd_rd,
    output logic        o_opnd_rd_we,
    output logic        o_sb_err
);

    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] busy;
    logic [31:0] set_mask, clr_mask;
    logic        hazard, accept, wb_act, rd_act, consume;

    logic [4:0]  rs1_q, rs2_q, rd_q;
    logic        rd_we_q;

    // last driven port values, held while the port is idle
    logic        op_q;
    logic [4:0]  r1_q, r2_q, wn_q;
    logic [31:0] wv_q;

    assign hazard = busy[i_rs1] | busy[i_rs2] | (i_rd_we & busy[i_rd]);
    assign wb_act = i_wb_valid && (i_wb_rd != 5'd0);
    assign accept = i_issue_valid && o_issue_ready;

    always_comb begin
        state_nxt     = state;
        o_issue_ready = 1'b0;
        rd_act        = 1'b0;
        consume       = 1'b0;
        case (state)
            IDLE: begin
                o_issue_ready = !hazard && !i_wb_valid;
                if (i_issue_valid && !hazard && !i_wb_valid) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (!i_wb_valid) begin
                    rd_act    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (i_opnd_ready) begin
                    consume   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_rf_en       = wb_act | rd_act;
    assign o_op          = wb_act ? 1'b1 : (rd_act ? 1'b0 : op_q);
    assign o_r_reg_num_1 = rd_act ? rs1_q : r1_q;
    assign o_r_reg_num_2 = rd_act ? rs2_q : r2_q;
    assign o_w_reg_num   = wb_act ? i_wb_rd : wn_q;
    assign o_w_val       = wb_act ? i_wb_val : wv_q;

    // bit 0 is masked off so x0 never appears busy
    assign set_mask = (accept && i_rd_we) ? (32'd1 << i_rd) : 32'd0;
    assign clr_mask = wb_act ? (32'd1 << i_wb_rd) : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 32'd0;
        end else begin
            state <= state_nxt;
            busy  <= (busy | set_mask) & ~clr_mask & 32'hFFFF_FFFE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sb_err <= 1'b0;
        end else if (wb_act && !busy[i_wb_rd]) begin
            o_sb_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q   <= 5'd0;
            rs2_q   <= 5'd0;
            rd_q    <= 5'd0;
            rd_we_q <= 1'b0;
        end else if (accept) begin
            rs1_q   <= i_rs1;
            rs2_q   <= i_rs2;
            rd_q    <= i_rd;
            rd_we_q <= i_rd_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_opnd_valid <= 1'b0;
            o_opnd_1     <= 32'd0;
            o_opnd_2     <= 32'd0;
            o_opnd_rd    <= 5'd0;
            o_opnd_rd_we <= 1'b0;
        end else if (rd_act) begin
            o_opnd_valid <= 1'b1;
            o_opnd_1     <= (rs1_q == 5'd0) ? 32'd0 : i_r_reg_1;
            o_opnd_2     <= (rs2_q == 5'd0) ? 32'd0 : i_r_reg_2;
            o_opnd_rd    <= rd_q;
            o_opnd_rd_we <= rd_we_q;
        end else if (consume) begin
            o_opnd_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= 1'b0;
            r1_q <= 5'd0;
            r2_q <= 5'd0;
            wn_q <= 5'd0;
            wv_q <= 32'd0;
        end else if (wb_act) begin
            op_q <= 1'b1;
            wn_q <= i_wb_rd;
            wv_q <= i_wb_val;
        end else if (rd_act) begin
            op_q <= 1'b0;
            r1_q <= rs1_q;
            r2_q <= rs2_q;
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Randomized and directed bench for regfile_access_ctrl against a transaction-level model.
module tb_regfile_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_issue_valid = 1'b0;
    logic        o_issue_ready;
    logic [4:0]  i_rs1 = '0, i_rs2 = '0, i_rd = '0;
    logic        i_rd_we = 1'b0;
    logic        i_wb_valid = 1'b0;
    logic [4:0]  i_wb_rd = '0;
    logic [31:0] i_wb_val = '0;
    logic        o_rf_en, o_op;
    logic [4:0]  o_r_reg_num_1, o_r_reg_num_2;
    logic [31:0] i_r_reg_1, i_r_reg_2;
    logic [4:0]  o_w_reg_num;
    logic [31:0] o_w_val;
    logic        o_opnd_valid;
    logic        i_opnd_ready = 1'b0;
    logic [31:0] o_opnd_1, o_opnd_2;
    logic [4:0]  o_opnd_rd;
    logic        o_opnd_rd_we;
    logic        o_sb_err;

    always #5 clk = ~clk;

    regfile_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .i_issue_valid(i_issue_valid), .o_issue_ready(o_issue_ready),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_rd_we(i_rd_we),
        .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_wb_val(i_wb_val),
        .o_rf_en(o_rf_en), .o_op(o_op),
        .o_r_reg_num_1(o_r_reg_num_1), .o_r_reg_num_2(o_r_reg_num_2),
        .i_r_reg_1(i_r_reg_1), .i_r_reg_2(i_r_reg_2),
        .o_w_reg_num(o_w_reg_num), .o_w_val(o_w_val),
        .o_opnd_valid(o_opnd_valid), .i_opnd_ready(i_opnd_ready),
        .o_opnd_1(o_opnd_1), .o_opnd_2(o_opnd_2),
        .o_opnd_rd(o_opnd_rd), .o_opnd_rd_we(o_opnd_rd_we),
        .o_sb_err(o_sb_err)
    );

    // register file stub; x0 deliberately holds junk so the DUT's zero forcing is visible
    logic [31:0] rf [32];
    assign i_r_reg_1 = rf[o_r_reg_num_1];
    assign i_r_reg_2 = rf[o_r_reg_num_2];

    int n_checks = 0;
    int n_errors = 0;

    // reference model: architectural values, busy set, one outstanding instruction
    logic [31:0] m_val [32];
    bit          m_busy [32];
    bit          m_err, m_inflight, m_pend;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    bit          m_we;
    bit          e_valid, e_we;
    logic [31:0] e_op1, e_op2;
    logic [4:0]  e_rd;
    bit          last_op, w_known;
    logic [4:0]  last_r1, last_r2, last_wn;
    logic [31:0] last_wv;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        m_err = 0; m_inflight = 0; m_pend = 0;
        e_valid = 0;
        last_op = 0; last_r1 = '0; last_r2 = '0; w_known = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_issue_valid = 0; i_wb_valid = 0; i_opnd_ready = 0; i_rd_we = 0;
        i_rs1 = '0; i_rs2 = '0; i_rd = '0; i_wb_rd = '0;
        #1;
        check("rst_opnd_valid", {31'd0, o_opnd_valid}, 32'd0);
        check("rst_sb_err", {31'd0, o_sb_err}, 32'd0);
        check("rst_rf_en", {31'd0, o_rf_en}, 32'd0);
        check("rst_op", {31'd0, o_op}, 32'd0);
        check("rst_rnum1", {27'd0, o_r_reg_num_1}, 32'd0);
        check("rst_rnum2", {27'd0, o_r_reg_num_2}, 32'd0);
        check("rst_opnd_1", o_opnd_1, 32'd0);
        check("rst_opnd_2", o_opnd_2, 32'd0);
        check("rst_opnd_rd", {27'd0, o_opnd_rd}, 32'd0);
        check("rst_opnd_rd_we", {31'd0, o_opnd_rd_we}, 32'd0);
        check("rst_issue_ready", {31'd0, o_issue_ready}, 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input bit iv, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input bit we, input bit wv,
                        input logic [4:0] wrd, input logic [31:0] wval, input bit ordy);
        bit hz, exp_rdy, rd_now, wb_act, cons;
        @(negedge clk);
        i_issue_valid = iv; i_rs1 = rs1; i_rs2 = rs2; i_rd = rd; i_rd_we = we;
        i_wb_valid = wv; i_wb_rd = wrd; i_wb_val = wval; i_opnd_ready = ordy;
        #2;
        hz      = m_busy[rs1] | m_busy[rs2] | (we & m_busy[rd]);
        exp_rdy = !m_inflight && !hz && !wv;
        rd_now  = m_pend && !wv;
        wb_act  = wv && (wrd != 5'd0);
        cons    = e_valid && ordy;
        check("issue_ready", {31'd0, o_issue_ready}, {31'd0, exp_rdy});
        check("rf_en", {31'd0, o_rf_en}, {31'd0, wb_act | rd_now});
        if (wb_act) begin
            check("wr_op", {31'd0, o_op}, 32'd1);
            check("wr_num", {27'd0, o_w_reg_num}, {27'd0, wrd});
            check("wr_val", o_w_val, wval);
            rf[o_w_reg_num] = o_w_val;
            last_op = 1; last_wn = wrd; last_wv = wval; w_known = 1;
        end else if (rd_now) begin
            check("rd_op", {31'd0, o_op}, 32'd0);
            check("rd_num1", {27'd0, o_r_reg_num_1}, {27'd0, m_rs1});
            check("rd_num2", {27'd0, o_r_reg_num_2}, {27'd0, m_rs2});
            last_op = 0; last_r1 = m_rs1; last_r2 = m_rs2;
        end else begin
            check("hold_op", {31'd0, o_op}, {31'd0, last_op});
            check("hold_rnum1", {27'd0, o_r_reg_num_1}, {27'd0, last_r1});
            check("hold_rnum2", {27'd0, o_r_reg_num_2}, {27'd0, last_r2});
            if (w_known) begin
                check("hold_wnum", {27'd0, o_w_reg_num}, {27'd0, last_wn});
                check("hold_wval", o_w_val, last_wv);
            end
        end
        check("opnd_valid", {31'd0, o_opnd_valid}, {31'd0, e_valid});
        if (e_valid) begin
            check("opnd_1", o_opnd_1, e_op1);
            check("opnd_2", o_opnd_2, e_op2);
            check("opnd_rd", {27'd0, o_opnd_rd}, {27'd0, e_rd});
            check("opnd_rd_we", {31'd0, o_opnd_rd_we}, {31'd0, e_we});
        end
        check("sb_err", {31'd0, o_sb_err}, {31'd0, m_err});

        if (rd_now) begin
            e_valid = 1; e_op1 = m_val[m_rs1]; e_op2 = m_val[m_rs2];
            e_rd = m_rd; e_we = m_we; m_pend = 0;
        end
        if (cons) begin
            e_valid = 0; m_inflight = 0;
        end
        if (wb_act) begin
            if (!m_busy[wrd]) m_err = 1;
            m_busy[wrd] = 0;
            m_val[wrd] = wval;
        end
        if (iv && exp_rdy) begin
            m_inflight = 1; m_pend = 1;
            m_rs1 = rs1; m_rs2 = rs2; m_rd = rd; m_we = we;
            if (we && rd != 5'd0) m_busy[rd] = 1;
        end
    endtask

    task automatic idle(input bit ordy);
        step(0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 32'd0, ordy);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            rf[r] = $urandom;
            m_val[r] = rf[r];
        end
        rf[3] = 32'h11; m_val[3] = 32'h11;
        rf[4] = 32'h22; m_val[4] = 32'h22;
        rf[0] = 32'hDEAD_BEEF; m_val[0] = 32'd0;
        model_reset();
        do_reset();

        // basic issue: operands from x3/x4, x5 becomes busy
        step(1, 5'd3, 5'd4, 5'd5, 1, 0, 5'd0, 32'd0, 0);
        idle(0);
        idle(0);
        idle(1);
        // RAW on x5: stall, writeback clears it, issue next cycle
        step(1, 5'd5, 5'd0, 5'd6, 1, 0, 5'd0, 32'd0, 0);
        step(1, 5'd5, 5'd0, 5'd6, 1, 0, 5'd0, 32'd0, 0);
        step(1, 5'd5, 5'd0, 5'd6, 1, 1, 5'd5, 32'hABCD, 0);
        step(1, 5'd5, 5'd0, 5'd6, 1, 0, 5'd0, 32'd0, 0);
        idle(0);
        idle(1);
        // writeback collides with the read cycle
        step(1, 5'd3, 5'd4, 5'd8, 1, 0, 5'd0, 32'd0, 0);
        step(0, 5'd0, 5'd0, 5'd0, 0, 1, 5'd6, 32'h1234, 0);
        idle(0);
        idle(1);
        // all-x0 instruction, then a dropped writeback to x0
        step(1, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 32'd0, 0);
        idle(0);
        idle(1);
        step(0, 5'd0, 5'd0, 5'd0, 0, 1, 5'd0, 32'h55, 0);
        // writeback to a register that is not busy
        step(0, 5'd0, 5'd0, 5'd0, 0, 1, 5'd7, 32'h77, 0);
        idle(0);

        for (int c = 0; c < 2000; c++) begin
            logic [4:0] cand[$];
            logic [4:0] wrd;
            bit wv;
            for (int r = 1; r < 8; r++) if (m_busy[r]) cand.push_back(5'(r));
            wv = ($urandom_range(0, 99) < 30);
            if (cand.size() > 0 && $urandom_range(0, 9) < 8)
                wrd = cand[$urandom_range(0, cand.size() - 1)];
            else
                wrd = 5'($urandom_range(0, 7));
            step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                 wv, wrd, $urandom, $urandom_range(0, 9) < 6);
        end

        // reset while operands are held
        do_reset();
        step(1, 5'd1, 5'd2, 5'd5, 1, 0, 5'd0, 32'd0, 0);
        for (int k = 0; k < 5; k++) idle(0);
        do_reset();
        step(1, 5'd5, 5'd5, 5'd9, 1, 0, 5'd0, 32'd0, 0);
        idle(0);
        idle(1);
        idle(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Initiator-side controller for the integer register file (32 x 32-bit, x0 hard-zero). It accepts decoded instructions (rs1, rs2, rd) from decode, resolves read-after-write and write-after-write hazards against in-flight writebacks with a 31-entry busy scoreboard, and sequences the register file's single shared read/write port. It delivers operands to execute and accepts writebacks from the writeback stage, giving writebacks priority over reads.

## Interface
- No parameters; widths fixed: 5-bit register numbers, 32-bit data.
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_issue_valid  in  1  decode presents an instruction
- o_issue_ready  out  1  instruction accepted this cycle when both valid and ready are high
- i_rs1, i_rs2  in  5 each  source register numbers
- i_rd  in  5  destination register number
- i_rd_we  in  1  instruction writes rd
- i_wb_valid  in  1  writeback request this cycle (no backpressure)
- i_wb_rd  in  5  writeback register number
- i_wb_val  in  32  writeback data
- o_rf_en  out  1  register file port active this cycle
- o_op  out  1  port operation: 0 read, 1 write
- o_r_reg_num_1, o_r_reg_num_2  out  5 each  read addresses
- i_r_reg_1, i_r_reg_2  in  32 each  read data, combinational from the register file, same cycle as o_op=0
- o_w_reg_num  out  5  write address
- o_w_val  out  32  write data
- o_opnd_valid  out  1  operands valid to execute
- i_opnd_ready  in  1  execute consumes operands
- o_opnd_1, o_opnd_2  out  32 each  operand values
- o_opnd_rd  out  5; o_opnd_rd_we  out  1  passed-through destination info
- o_sb_err  out  1  sticky: writeback to a non-busy register

## Operation
- Scoreboard: busy[31:1]; busy[0] reads as 0 at all times.
- Hazard = busy[i_rs1] | busy[i_rs2] | (i_rd_we & busy[i_rd]).
- FSM states: IDLE, READ, HOLD.
- IDLE: o_issue_ready = !hazard & !i_wb_valid. On accept, latch rs1/rs2/rd/rd_we. If i_rd_we and i_rd != 0, set busy[i_rd]. Go to READ.
- READ: if i_wb_valid, the write owns the port and the FSM stays in READ. Otherwise drive o_rf_en=1, o_op=0 and o_r_reg_num_1/2 = the latched rs1/rs2. Capture i_r_reg_1/2 into o_opnd_1/2, forcing 0 for any operand whose register is 0. Set o_opnd_valid and go to HOLD.
- HOLD: hold the operands stable. When i_opnd_ready is high, clear o_opnd_valid and go to IDLE. o_issue_ready = 0 in READ and in HOLD.
- Writeback, any state, when i_wb_valid and i_wb_rd != 0:
  - o_rf_en=1, o_op=1, o_w_reg_num=i_wb_rd, o_w_val=i_wb_val. These are combinational from the inputs.
  - Clear busy[i_wb_rd] at the edge.
  - If busy[i_wb_rd] was already 0, set o_sb_err.
- A writeback to x0 is dropped: no port activity and no scoreboard or error change.
- Port is idle: o_rf_en=0; o_op, o_r_reg_num_*, o_w_* hold their last values.
- No bypass: a writeback that clears a hazard in cycle N allows issue in cycle N+1 at the earliest.
- WAW is prevented by stalling, so set and clear of the same busy bit never coincide.
- A source equal to rd in the same instruction reads the old value, because the hazard is checked before busy is set.

## Timing
- Reset (async assert, sync release): state=IDLE; busy=0; o_opnd_valid=0; o_opnd_1/2=0; o_opnd_rd=0; o_opnd_rd_we=0; o_sb_err=0; o_rf_en=0; o_op=0; o_r_reg_num_*=0.
- Reset mid-operation discards any latched or held instruction and clears all busy bits.
- Latency: accept in cycle N, read in N+1, o_opnd_valid=1 in N+2. Each writeback during READ adds one cycle.
- Throughput: at most one issue per 3 cycles. Back-to-back issue requires i_opnd_ready=1 in the first HOLD cycle.
- o_issue_ready depends combinationally on i_issue_* and i_wb_valid.
- o_sb_err clears only on reset.

## Test plan
- Reset then issue rs1=3, rs2=4, rd=5, we=1, with the register file holding x3=0x11 and x4=0x22 -> o_opnd_valid in cycle 2 with 0x11/0x22; busy[5]=1.
- RAW: issue rd=5 we=1, then issue rs1=5 -> o_issue_ready=0 until wb rd=5 val=0xABCD. Issue is accepted the next cycle, and operand 1 = 0xABCD.
- Writeback arriving in the READ cycle -> o_op=1 with the wb data that cycle. Read happens the following cycle; operands valid in cycle 3.
- rs1=0, rs2=0, rd=0, we=1 -> operands 0/0, no busy bit set. Then wb rd=0 -> o_rf_en stays 0 and o_sb_err stays 0.
- wb rd=7 with busy[7]=0 -> register write occurs and o_sb_err=1, remaining set through later traffic.
- Hold i_opnd_ready=0 for 4 cycles, then assert rst_n=0 -> o_opnd_valid=0 and busy cleared immediately. After release, an issue of rs1=5 is accepted without stall.
